// File: rtl/cy_control_reg_pkg.sv
// Shared constants, bit-mode type and parameter checking for the control register family.
// Every module that instantiates the register imports this package.
package cy_control_reg_pkg;

    localparam int unsigned CY_CTRL_MAX_WIDTH = 32;
    localparam int unsigned CY_CTRL_CNT_W     = 8;

    typedef enum logic {
        CY_CTRL_LEVEL = 1'b0,
        CY_CTRL_PULSE = 1'b1
    } cy_ctrl_mode_e;

    function automatic cy_ctrl_mode_e cy_ctrl_bit_mode(
        input logic [CY_CTRL_MAX_WIDTH-1:0] mask,
        input int unsigned                  idx
    );
        return mask[idx] ? CY_CTRL_PULSE : CY_CTRL_LEVEL;
    endfunction

endpackage

// Rejects out-of-range Width / PulseCycles at elaboration time.
`define CY_CTRL_CHECK_PARAMS(W, PC) \
    if (!((W) >= 1 && (W) <= CY_CTRL_MAX_WIDTH && (PC) >= 1 && (PC) <= 255)) begin : g_param_check \
        $error("cy_control_reg: illegal Width or PulseCycles"); \
    end

// File: rtl/cy_ctrl_pulse_bit.sv
// One self-clearing strobe bit: an 8-bit down-counter reloaded by trig, active while nonzero.
// A trigger in any cycle, including the last active one, reloads the counter.
module cy_ctrl_pulse_bit
    import cy_control_reg_pkg::*;
#(
    parameter int unsigned PulseCycles = 1
) (
    input  logic clock,
    input  logic reset_n,
    input  logic trig,
    output logic active
);

    localparam logic [CY_CTRL_CNT_W-1:0] LOAD = CY_CTRL_CNT_W'(PulseCycles);

    logic [CY_CTRL_CNT_W-1:0] count;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (trig) begin
            count <= LOAD;
        end else if (count != '0) begin
            count <= count - CY_CTRL_CNT_W'(1);
        end
    end

    assign active = (count != '0);

endmodule

// File: rtl/cy_control_reg_v2.sv
// Bus-written control register: per-bit LEVEL (stored) or PULSE (timed strobe) outputs,
// with masked writes, readback and a busy flag covering all active strobes.
module cy_control_reg_v2
    import cy_control_reg_pkg::*;
#(
    parameter int unsigned                  Width       = 8,
    parameter logic [CY_CTRL_MAX_WIDTH-1:0] PulseMask   = '0,
    parameter int unsigned                  PulseCycles = 1,
    parameter logic [CY_CTRL_MAX_WIDTH-1:0] InitValue   = '0
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             wr_en,
    input  logic [Width-1:0] wr_data,
    input  logic [Width-1:0] wr_mask,
    output logic [Width-1:0] control,
    output logic [Width-1:0] rd_data,
    output logic             busy
);

    `CY_CTRL_CHECK_PARAMS(Width, PulseCycles)

    localparam logic [Width-1:0] PULSE_BITS = PulseMask[Width-1:0];

    logic [Width-1:0] level_q;
    logic [Width-1:0] level_we;
    logic [Width-1:0] pulse_act;

    // PULSE positions in level_q are held at 0 so the two vectors can simply be OR-ed.
    assign level_we = {Width{wr_en}} & wr_mask & ~PULSE_BITS;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            level_q <= InitValue[Width-1:0] & ~PULSE_BITS;
        end else begin
            level_q <= (level_q & ~level_we) | (wr_data & level_we);
        end
    end

    for (genvar i = 0; i < Width; i++) begin : g_bit
        if (cy_ctrl_bit_mode(PulseMask, i) == CY_CTRL_PULSE) begin : g_pulse
            cy_ctrl_pulse_bit #(
                .PulseCycles(PulseCycles)
            ) u_pulse (
                .clock  (clock),
                .reset_n(reset_n),
                .trig   (wr_en & wr_mask[i] & wr_data[i]),
                .active (pulse_act[i])
            );
        end else begin : g_level
            assign pulse_act[i] = 1'b0;
        end
    end

    assign control = level_q | pulse_act;
    assign rd_data = control;
    assign busy    = |pulse_act;

endmodule

// File: tb/tb_cy_control_reg_v2.sv
// Scoreboard bench: the driver queues hand-computed expectations per cycle (or per async event),
// a monitor pops and compares control, rd_data and busy.
module tb_cy_control_reg_v2;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       wr_en;
    logic [7:0] wr_data;
    logic [7:0] wr_mask;
    logic [7:0] control;
    logic [7:0] rd_data;
    logic       busy;

    int unsigned tests_run = 0;
    int unsigned tests_failed = 0;

    typedef struct {
        logic [7:0] ctrl;
        logic       busy;
        string      name;
    } exp_t;

    exp_t exp_q[$];
    event async_ev;

    // Bit 1 is the only PULSE bit; InitValue bit 1 is already 0, so reset shows 8'hA5.
    cy_control_reg_v2 #(
        .Width      (8),
        .PulseMask  (32'h0000_0002),
        .PulseCycles(3),
        .InitValue  (32'h0000_00A5)
    ) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .wr_en  (wr_en),
        .wr_data(wr_data),
        .wr_mask(wr_mask),
        .control(control),
        .rd_data(rd_data),
        .busy   (busy)
    );

    always #5 clock = ~clock;

    always @(negedge clock or async_ev) begin
        if (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            tests_run++;
            if (control !== e.ctrl) begin
                tests_failed++;
                $display("FAIL %s control got %h want %h", e.name, control, e.ctrl);
            end
            tests_run++;
            if (rd_data !== e.ctrl) begin
                tests_failed++;
                $display("FAIL %s rd_data got %h want %h", e.name, rd_data, e.ctrl);
            end
            tests_run++;
            if (busy !== e.busy) begin
                tests_failed++;
                $display("FAIL %s busy got %b want %b", e.name, busy, e.busy);
            end
        end
    end

    // Drive one cycle of inputs from a negedge; expectation is the state after the next posedge.
    task automatic step(input logic en, input logic [7:0] d, input logic [7:0] m,
                        input logic [7:0] ec, input logic eb, input string name);
        wr_en   = en;
        wr_data = d;
        wr_mask = m;
        @(posedge clock);
        exp_q.push_back('{ctrl: ec, busy: eb, name: name});
        @(negedge clock);
    endtask

    task automatic idle(input logic [7:0] ec, input logic eb, input string name);
        step(1'b0, 8'h00, 8'h00, ec, eb, name);
    endtask

    task automatic expect_now(input logic [7:0] ec, input logic eb, input string name);
        exp_q.push_back('{ctrl: ec, busy: eb, name: name});
        -> async_ev;
        #0;
    endtask

    initial begin
        reset_n = 1'b0;
        wr_en   = 1'b0;
        wr_data = '0;
        wr_mask = '0;
        repeat (2) @(negedge clock);
        #1 expect_now(8'hA5, 1'b0, "reset_init");
        @(negedge clock);
        reset_n = 1'b1;
        idle(8'hA5, 1'b0, "after_release");

        // Masked write: level bits 0,2,3 set, pulse bit 1 fires; upper nibble untouched.
        step(1'b1, 8'hFF, 8'h0F, 8'hAF, 1'b1, "masked_write");
        idle(8'hAF, 1'b1, "pulse_c2");
        idle(8'hAF, 1'b1, "pulse_c3");
        idle(8'hAD, 1'b0, "pulse_end");
        step(1'b1, 8'hFF, 8'h00, 8'hAD, 1'b0, "mask0_noop");

        // Retrigger on the last active cycle: six consecutive high cycles.
        step(1'b1, 8'h02, 8'h02, 8'hAF, 1'b1, "rt_c1");
        idle(8'hAF, 1'b1, "rt_c2");
        idle(8'hAF, 1'b1, "rt_c3");
        step(1'b1, 8'h02, 8'h02, 8'hAF, 1'b1, "rt_c4");
        idle(8'hAF, 1'b1, "rt_c5");
        idle(8'hAF, 1'b1, "rt_c6");
        idle(8'hAD, 1'b0, "rt_end");

        // Writing 0 to an active pulse bit is ignored; level bit 6 updates in the same write.
        step(1'b1, 8'h02, 8'h02, 8'hAF, 1'b1, "w0_c1");
        step(1'b1, 8'h40, 8'h42, 8'hEF, 1'b1, "w0_c2");
        idle(8'hEF, 1'b1, "w0_c3");
        idle(8'hED, 1'b0, "w0_end");

        // Reset with the counter at 2: async clear, held, no residual pulse after release.
        step(1'b1, 8'h02, 8'h02, 8'hEF, 1'b1, "rst_trig");
        idle(8'hEF, 1'b1, "rst_cnt2");
        #2 reset_n = 1'b0;
        #1 expect_now(8'hA5, 1'b0, "rst_async");
        @(negedge clock);
        step(1'b1, 8'hFF, 8'hFF, 8'hA5, 1'b0, "rst_held");
        reset_n = 1'b1;
        idle(8'hA5, 1'b0, "rst_post1");
        idle(8'hA5, 1'b0, "rst_post2");
        idle(8'hA5, 1'b0, "rst_post3");

        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clock);
        if (exp_q.size() != 0) begin
            tests_run++;
            tests_failed++;
            $display("FAIL drain pending %0d want 0", exp_q.size());
        end
        #1;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
